seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with blanking gaps and frame-synchronous value commit.
// Optional leading-zero suppression is enabled by defining SEG_ZERO_BLANK_EN.
module seg_scan_ctrl #(
    parameter int DIV   = 41248,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        data_we,
    output logic        pending,
    output logic [7:0]  dig_an_n,
    output logic [7:0]  seg_n
);

    localparam int                 CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_BLANK = CNT_W'(BLANK);

    localparam logic [0:0] ST_GAP  = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      disp_q, disp_d;
    logic [31:0]      shd_q, shd_d;
    logic             pending_q, pending_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic [0:0] state;
    logic       slot_end;
    logic       frame_end;
    logic       digit_on;
    logic [3:0] nib;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

`ifdef SEG_ZERO_BLANK_EN
    logic [2:0] msd;

    // Highest nonzero nibble; digit 0 stays visible even when the value is zero.
    always_comb begin
        msd = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (disp_q[4*k +: 4] != 4'h0) msd = 3'(k);
        end
    end

    assign digit_on = (idx_q <= msd);
`else
    assign digit_on = 1'b1;
`endif

    assign state     = (cnt_q < CNT_BLANK) ? ST_GAP : ST_SHOW;
    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 3'd7);
    assign nib       = disp_q[{idx_q, 2'b00} +: 4];

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        disp_d    = disp_q;
        shd_d     = shd_q;
        pending_d = pending_q;
        an_d      = 8'hFF;
        seg_d     = 8'hFF;

        if (slot_end) idx_d = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;

        if (data_we) begin
            shd_d     = data_in;
            pending_d = 1'b1;
        end

        // A write landing on the boundary edge bypasses the shadow and commits immediately.
        if (frame_end) begin
            if (data_we) begin
                disp_d    = data_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                disp_d    = shd_q;
                pending_d = 1'b0;
            end
        end

        if (state == ST_SHOW && digit_on) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex7(nib);
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    // NOTE: the data registers are plain flops, so resetting them is cheap and keeps a lost write from reappearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            disp_q    <= 32'h0;
            shd_q     <= 32'h0;
            pending_q <= 1'b0;
            an_q      <= 8'hFF;
            seg_q     <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shd_q     <= shd_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign pending  = pending_q;
    assign dig_an_n = an_q;
    assign seg_n    = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIV=8, BLANK=2 (64-cycle frames).
// Outputs are sampled 1 ns after each rising edge; edge counter e restarts at 0 on every reset release.
module tb_seg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        data_we;
    logic        pending;
    logic [7:0]  dig_an_n;
    logic [7:0]  seg_n;

    int n_checks = 0;
    int n_errors = 0;
    int e        = 0;

    logic [7:0] hex_tab [16];

    typedef struct {
        logic        we;
        logic [31:0] din;
        logic [7:0]  an;
        logic [7:0]  seg;
        logic        pend;
    } vec_t;

    vec_t tab [12];

    seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_we  (data_we),
        .pending  (pending),
        .dig_an_n (dig_an_n),
        .seg_n    (seg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, e, act, exp);
        end
    endtask

    // Expected pins for edge e: outputs reflect the slot state held just before that edge.
    function automatic void model(input int ed, input logic [31:0] d,
                                  output logic [7:0] an, output logic [7:0] seg);
        int c, i, msd;
        logic [3:0] nb;
        c   = (ed - 1) % DIV;
        i   = ((ed - 1) / DIV) % 8;
        an  = 8'hFF;
        seg = 8'hFF;
        msd = 7;
`ifdef SEG_ZERO_BLANK_EN
        msd = 0;
        for (int k = 1; k < 8; k++) if (((d >> (4*k)) & 32'hF) != 0) msd = k;
`endif
        if (c >= BLANK && i <= msd) begin
            nb  = 4'(d >> (4*i));
            an  = ~(8'h01 << i);
            seg = hex_tab[nb];
        end
    endfunction

    task automatic cyc(input logic we, input logic [31:0] din, input logic [31:0] dexp);
        logic [7:0] an_e, seg_e;
        data_we = we;
        data_in = din;
        @(posedge clk);
        #1;
        data_we = 1'b0;
        e++;
        model(e, dexp, an_e, seg_e);
        check("dig_an_n", {24'h0, dig_an_n}, {24'h0, an_e});
        check("seg_n", {24'h0, seg_n}, {24'h0, seg_e});
    endtask

    task automatic run(input int n, input logic [31:0] dexp);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, dexp);
    endtask

    task automatic run_pend(input int n, input logic [31:0] dexp, input logic pexp);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 32'h0, dexp);
            check("pending", {31'h0, pending}, {31'h0, pexp});
        end
    endtask

    initial begin
        hex_tab[0]  = 8'hC0; hex_tab[1]  = 8'hF9; hex_tab[2]  = 8'hA4; hex_tab[3]  = 8'hB0;
        hex_tab[4]  = 8'h99; hex_tab[5]  = 8'h92; hex_tab[6]  = 8'h82; hex_tab[7]  = 8'hF8;
        hex_tab[8]  = 8'h80; hex_tab[9]  = 8'h90; hex_tab[10] = 8'h88; hex_tab[11] = 8'h83;
        hex_tab[12] = 8'hC6; hex_tab[13] = 8'hA1; hex_tab[14] = 8'h86; hex_tab[15] = 8'h8E;

        // Edges 1..12 after reset release: gap, digit 0 for six cycles, gap, digit 1.
        tab[0]  = '{1'b0, 32'h0, 8'hFF, 8'hFF, 1'b0};
        tab[1]  = '{1'b0, 32'h0, 8'hFF, 8'hFF, 1'b0};
        for (int k = 2; k < 8; k++) tab[k] = '{1'b0, 32'h0, 8'hFE, 8'hC0, 1'b0};
        tab[8]  = '{1'b0, 32'h0, 8'hFF, 8'hFF, 1'b0};
        tab[9]  = '{1'b0, 32'h0, 8'hFF, 8'hFF, 1'b0};
        tab[10] = '{1'b0, 32'h0, 8'hFD, 8'hC0, 1'b0};
        tab[11] = '{1'b0, 32'h0, 8'hFD, 8'hC0, 1'b0};

        rst_n   = 1'b0;
        data_we = 1'b0;
        data_in = 32'h0;
        #12;
        check("reset dig_an_n", {24'h0, dig_an_n}, 32'hFF);
        check("reset seg_n", {24'h0, seg_n}, 32'hFF);
        check("reset pending", {31'h0, pending}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            data_we = tab[k].we;
            data_in = tab[k].din;
            @(posedge clk);
            #1;
            data_we = 1'b0;
            e++;
            check("tab dig_an_n", {24'h0, dig_an_n}, {24'h0, tab[k].an});
            check("tab seg_n", {24'h0, seg_n}, {24'h0, tab[k].seg});
            check("tab pending", {31'h0, pending}, {31'h0, tab[k].pend});
        end

        // Steady scan of zeros through edge 140 (covers two full frame boundaries at 64 and 128).
        run_pend(128, 32'h0, 1'b0);

        // Single write mid-frame; commits at boundary edge 192.
        cyc(1'b1, 32'h0000_00A1, 32'h0);
        check("pending after write", {31'h0, pending}, 32'h1);
        run_pend(50, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0);
        check("pending at boundary", {31'h0, pending}, 32'h0);
        run_pend(64, 32'h0000_00A1, 1'b0);

        // Two writes in one frame: last write wins, one commit at edge 320.
        run(3, 32'h0000_00A1);
        cyc(1'b1, 32'h1111_1111, 32'h0000_00A1);
        cyc(1'b1, 32'h2222_2222, 32'h0000_00A1);
        check("pending after 2 writes", {31'h0, pending}, 32'h1);
        run_pend(58, 32'h0000_00A1, 1'b1);
        cyc(1'b0, 32'h0, 32'h0000_00A1);
        check("pending at 2nd boundary", {31'h0, pending}, 32'h0);
        run_pend(63, 32'h2222_2222, 1'b0);

        // Write on the commit edge itself (edge 384): direct load, pending never rises.
        cyc(1'b1, 32'h0000_00F0, 32'h2222_2222);
        check("pending write on commit", {31'h0, pending}, 32'h0);
        run_pend(64, 32'h0000_00F0, 1'b0);

        // Uncommitted write, then reset mid-SHOW of digit 1 (edge 462).
        run(9, 32'h0000_00F0);
        cyc(1'b1, 32'h1234_5678, 32'h0000_00F0);
        run(4, 32'h0000_00F0);
        check("pre-reset dig_an_n", {24'h0, dig_an_n}, 32'hFD);
        check("pre-reset pending", {31'h0, pending}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset dig_an_n", {24'h0, dig_an_n}, 32'hFF);
        check("async reset seg_n", {24'h0, seg_n}, 32'hFF);
        check("async reset pending", {31'h0, pending}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        run_pend(69, 32'h0, 1'b0);

        // Value with leading zeros; suppression applies only when the option is built in.
        cyc(1'b1, 32'h0000_0A10, 32'h0);
        check("pending A10", {31'h0, pending}, 32'h1);
        run(58, 32'h0);
        check("pending A10 boundary", {31'h0, pending}, 32'h0);
        run_pend(64, 32'h0000_0A10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
